// File: rtl/id_ex_pipe_stage_if.sv
// rtl/id_ex_pipe_stage_if.sv - decode-side and execute-side handshake/payload bundle of the ID/EX stage
interface id_ex_pipe_stage_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 4,
    parameter int CTRL_W   = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_DATA*DATA_W-1:0] in_data;
    logic [CTRL_W-1:0]          in_ctrl;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_DATA*DATA_W-1:0] out_data;
    logic [CTRL_W-1:0]          out_ctrl;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/id_ex_pipe_stage.sv
// rtl/id_ex_pipe_stage.sv - ID/EX stage register with handshake, hit stall, flush bubble and perf counters
// Optional skid entry (registered in_ready) enabled by defining ID_EX_SKID_EN.
module id_ex_pipe_stage #(
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 4,
    parameter int CTRL_W   = 16,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hit,
    input  logic                   flush,
    id_ex_pipe_stage_if.slave      bus,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       bubble_cnt
);
    localparam int PW = NUM_DATA * DATA_W;

    typedef enum logic [1:0] {EMPTY, HALF, FULL} stateT;

    stateT             state, nextState;
    logic [PW-1:0]     mData;
    logic [CTRL_W-1:0] mCtrl;
    logic              mValid;
    logic              inReady, inFire, outFire;
    logic              loadMIn, loadMS, loadS;

    assign mValid = (state != EMPTY);

`ifdef ID_EX_SKID_EN
    logic [PW-1:0]     sData;
    logic [CTRL_W-1:0] sCtrl;

    // Ready depends only on registered state: drops once S is occupied.
    assign inReady = rst_n & hit & ~flush & (state != FULL);
`else
    assign inReady = rst_n & hit & ~flush & (~mValid | bus.out_ready);
`endif

    assign inFire  = bus.in_valid & inReady;
    assign outFire = mValid & bus.out_ready & hit;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= EMPTY;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        loadMIn   = 1'b0;
        loadMS    = 1'b0;
        loadS     = 1'b0;
        if (flush) begin
            nextState = EMPTY;
        end else begin
            case (state)
                EMPTY: if (inFire) begin
                    nextState = HALF;
                    loadMIn   = 1'b1;
                end
                HALF: begin
                    if (inFire && outFire) begin
                        loadMIn = 1'b1;
                    end else if (outFire) begin
                        nextState = EMPTY;
`ifdef ID_EX_SKID_EN
                    end else if (inFire) begin
                        nextState = FULL;
                        loadS     = 1'b1;
`endif
                    end
                end
`ifdef ID_EX_SKID_EN
                FULL: if (outFire) begin
                    nextState = HALF;
                    loadMS    = 1'b1;
                end
`endif
                default: nextState = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mData <= '0;
            mCtrl <= '0;
        end else if (loadMIn) begin
            mData <= bus.in_data;
            mCtrl <= bus.in_ctrl;
`ifdef ID_EX_SKID_EN
        end else if (loadMS) begin
            mData <= sData;
            mCtrl <= sCtrl;
`endif
        end
    end

`ifdef ID_EX_SKID_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sData <= '0;
            sCtrl <= '0;
        end else if (loadS) begin
            sData <= bus.in_data;
            sCtrl <= bus.in_ctrl;
        end
    end
`else
    logic unusedSkid;
    assign unusedSkid = loadMS | loadS;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (!hit && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
            if (hit && !mValid && bubble_cnt != {CNT_W{1'b1}})
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    // Data registers keep their contents on flush; the valid gate hides stale control.
    assign bus.in_ready  = inReady;
    assign bus.out_valid = mValid;
    assign bus.out_data  = mData;
    assign bus.out_ctrl  = mValid ? mCtrl : '0;
endmodule

// File: doc/id_ex_pipe_stage.md
# id_ex_pipe_stage

Parametrised ID/EX pipeline stage register that carries decoded operands and control fields from decode to execute. It generalises the fixed-field ID/EX register with configurable operand count and width, a valid/ready handshake, a cache-hit global stall, a flush that injects a NOP bubble, and an optional skid entry for full throughput with registered `in_ready`. It also provides stall and bubble counters for pipeline performance analysis.

## Interface
- `DATA_W`, 32, width of one operand word (readData1, readData2, immediate, nextPC, ...)
- `NUM_DATA`, 4, number of operand words carried
- `CTRL_W`, 16, width of packed control/field bus (RegDst, ALUSrc, ..., ALUOp, rt, rd, funct)
- `CNT_W`, 16, width of performance counters
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `hit`  in  1  memory hit; 0 = global stall, freezes all stage state
- `flush`  in  1  kill stage contents (branch taken / exception)
- `in_valid`  in  1  upstream has an instruction
- `in_ready`  out  1  stage accepts this cycle
- `in_data`  in  NUM_DATA*DATA_W  operand words, word 0 in LSBs
- `in_ctrl`  in  CTRL_W  control fields
- `out_valid`  out  1  execute-side instruction valid
- `out_ready`  in  1  execute accepts
- `out_data`  out  NUM_DATA*DATA_W  registered operands
- `out_ctrl`  out  CTRL_W  registered control; all-zero whenever `out_valid`=0
- `stall_cnt`  out  CNT_W  cycles with `hit`=0
- `bubble_cnt`  out  CNT_W  cycles with `hit`=1 and `out_valid`=0

## Operation
- Storage: main entry M (drives outputs) and, with skid enabled, skid entry S.
- `in_fire` = `in_valid` & `in_ready`; `out_fire` = `out_valid` & `out_ready` & `hit`.
- `in_ready` = `rst_n` & `hit` & !`flush` & !S_valid (skid build); no combinational dependency on `out_ready`.
- States: EMPTY (M empty), HALF (M full, S empty), FULL (M and S full).
  - EMPTY: `in_fire` -> HALF, M loads input.
  - HALF: `in_fire` & `out_fire` -> HALF, M reloads; `out_fire` only -> EMPTY; `in_fire` only (out stalled) -> FULL, S loads input.
  - FULL: `in_ready`=0; `out_fire` -> HALF, M loads S.
- `hit`=0: no state, data or valid change (except flush), `in_ready`=0, outputs held stable.
- `flush`=1: next cycle M_valid=S_valid=0 (EMPTY), regardless of `hit`; has priority over every transfer; input that cycle is not accepted. Data registers retain contents; `out_ctrl` reads zero via the valid gate.
- Order preserved: S never overtakes M; no loss, no duplication.
- Counters: `stall_cnt` +1 per cycle `hit`=0; `bubble_cnt` +1 per cycle `hit`=1 & `out_valid`=0; both saturate at 2^CNT_W-1, cleared only by reset.

## Timing
- Latency: input accepted at edge N appears on `out_*` after edge N (visible cycle N+1).
- Throughput: one instruction per cycle with `out_ready`=1 and `hit`=1.
- `in_ready` drops the cycle after S fills; rises the cycle after S drains.
- Reset (`rst_n`=0 at an edge): `out_valid`=0, `out_data`=0, `out_ctrl`=0, S cleared, `stall_cnt`=0, `bubble_cnt`=0; `in_ready`=0 while `rst_n`=0. Reset mid-transfer discards both entries.
- Simultaneous `flush` and `hit`=0: flush wins, stage empties.

## Configuration
- `ID_EX_SKID_EN` defined: S entry present, behaviour as above, `in_ready` purely registered-state based.
- Not defined: no S entry, FULL unreachable; `in_ready` = `rst_n` & `hit` & !`flush` & (!M_valid | `out_ready`), a combinational path from `out_ready`; latency and all other rules unchanged.

## Test plan
- Reset: `rst_n`=0 two cycles with `in_valid`=1 -> `out_valid`=0, `out_ctrl`=0, `out_data`=0, `in_ready`=0, counters 0.
- Stream: `hit`=1, `out_ready`=1, words {5,2,23,0}, then {6,3,24,4} on consecutive cycles -> outputs appear one cycle later each, in order, `bubble_cnt` stops incrementing while streaming.
- Back-pressure: A in M, `out_ready`=0, offer B -> skid: B accepted, `in_ready`=0 next cycle; `out_ready`=1 -> A then B on consecutive cycles. Without skid: B refused while `out_ready`=0.
- Hit stall: `hit`=0 for 3 cycles mid-stream -> `out_*` frozen, `in_ready`=0, no transfer despite `out_ready`=1, `stall_cnt`=3.
- Flush: stage FULL, `hit`=0, `flush`=1 -> next cycle `out_valid`=0, `out_ctrl`=0; with `hit`=1, `in_ready`=1 and new input passes normally.
- Saturation: CNT_W=4, 20 idle cycles at `hit`=1 -> `bubble_cnt`=15 and holds.
